// File: rtl/iter_div.sv
// iter_div
// Iterative radix-2 restoring divider for the execute stage. Produces one
// quotient bit per clock, supports signed and unsigned operation, exits early
// for a zero divisor or a divisor larger in magnitude than the dividend, and
// packs {remainder, quotient} so it drops into the HI/LO write path.
//
// Ports
//   clk       clock
//   rst       synchronous active-high reset
//   start     divide request, accepted in IDLE when annul is low
//   signed_i  1 = signed divide, 0 = unsigned; sampled with start in IDLE
//   dividend  numerator, sampled with start in IDLE
//   divisor   denominator, sampled with start in IDLE
//   annul     pipeline flush, cancels any operation in progress
//   hold      external stall, keeps a finished result presented in DONE
//   stall_o   request to freeze F/D/E while the divide is in flight
//   done_o    result valid
//   div0_o    divisor was zero (valid while done_o = 1)
//   result_o  {remainder, quotient}
module iter_div #(
   parameter int WIDTH      = 32,
   parameter int EARLY_TERM = 1,
   parameter int CNT_W      = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   input  logic               annul,
   input  logic               hold,
   output logic               stall_o,
   output logic               done_o,
   output logic               div0_o,
   output logic [2*WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FIX,
      DONE
   } DivState;

   DivState            state;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   remReg;
   logic [WIDTH-1:0]   quoReg;
   logic [WIDTH-1:0]   divisorReg;
   logic [WIDTH-1:0]   dividendReg;
   logic               quoNeg;
   logic               remNeg;
   logic               earlyExit;
   logic               divZero;
   logic               doneReg;
   logic               div0Reg;
   logic [2*WIDTH-1:0] resultReg;

   logic [WIDTH-1:0]   absDividend;
   logic [WIDTH-1:0]   absDivisor;
   logic [WIDTH-1:0]   fixedQuo;
   logic [WIDTH-1:0]   fixedRem;
   logic [WIDTH:0]     shiftedRem;
   logic [WIDTH:0]     trialDiff;
   logic               divisorZero;
   logic               earlyHit;

   // Operand magnitudes for the incoming request, the restoring step datapath
   // and the sign fix-up. The trial subtract is one bit wider than the
   // operands so its MSB acts as the borrow that decides whether to restore.
   // The most negative value negates to itself, which read as unsigned is
   // exactly its magnitude, so MIN operands need no special handling.
   always_comb begin
      absDividend = (signed_i && dividend[WIDTH-1]) ? -dividend : dividend;
      absDivisor  = (signed_i && divisor[WIDTH-1])  ? -divisor  : divisor;
      divisorZero = (divisor == '0);
      earlyHit    = (EARLY_TERM != 0) && (absDivisor > absDividend);
      shiftedRem  = {remReg, quoReg[WIDTH-1]};
      trialDiff   = shiftedRem - {1'b0, divisorReg};
      fixedQuo    = quoNeg ? -quoReg : quoReg;
      fixedRem    = remNeg ? -remReg : remReg;
   end

   // Stall request is combinational so the front of the pipe freezes in the
   // same cycle the request is seen; a flush releases it immediately.
   assign stall_o  = ~annul & (((state == IDLE) & start) | (state == BUSY) | (state == FIX));
   assign done_o   = doneReg;
   assign div0_o   = div0Reg;
   assign result_o = resultReg;

   // Main controller. IDLE latches magnitudes and result signs, BUSY runs one
   // restoring step per cycle with the quotient shifting in from the bottom
   // of quoReg as the dividend bits shift out of its top, FIX applies signs
   // or the trivial-case results, and DONE presents the result until hold
   // drops. A flush beats everything but reset and leaves result_o untouched
   // so an annulled divide never disturbs the last valid HI/LO value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         remReg      <= '0;
         quoReg      <= '0;
         divisorReg  <= '0;
         dividendReg <= '0;
         quoNeg      <= 1'b0;
         remNeg      <= 1'b0;
         earlyExit   <= 1'b0;
         divZero     <= 1'b0;
         doneReg     <= 1'b0;
         div0Reg     <= 1'b0;
         resultReg   <= '0;
      end else if (annul) begin
         state   <= IDLE;
         doneReg <= 1'b0;
         div0Reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dividendReg <= dividend;
                  divisorReg  <= absDivisor;
                  remReg      <= '0;
                  quoReg      <= absDividend;
                  quoNeg      <= signed_i & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  remNeg      <= signed_i & dividend[WIDTH-1];
                  divZero     <= divisorZero;
                  earlyExit   <= earlyHit;
                  div0Reg     <= 1'b0;
                  if (divisorZero || earlyHit) begin
                     state <= FIX;
                     count <= '0;
                  end else begin
                     state <= BUSY;
                     count <= CNT_W'(WIDTH);
                  end
               end
            end
            BUSY: begin
               if (trialDiff[WIDTH]) begin
                  remReg <= shiftedRem[WIDTH-1:0];
                  quoReg <= {quoReg[WIDTH-2:0], 1'b0};
               end else begin
                  remReg <= trialDiff[WIDTH-1:0];
                  quoReg <= {quoReg[WIDTH-2:0], 1'b1};
               end
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (divZero) begin
                  resultReg <= {dividendReg, {WIDTH{1'b1}}};
               end else if (earlyExit) begin
                  resultReg <= {dividendReg, {WIDTH{1'b0}}};
               end else begin
                  resultReg <= {fixedRem, fixedQuo};
               end
               div0Reg <= divZero;
               doneReg <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               if (!hold) begin
                  doneReg <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
